// File: rtl/mux_rr_nx1_if.sv
// Lane bundle for mux_rr_nx1: NCH valid-qualified input lanes with pop strobes,
// plus the single registered output lane carrying the source channel index.
interface mux_rr_nx1_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int CW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH-1:0]       valid_in;
  logic                 out_ready;
  logic [NCH-1:0]       pop_out;
  logic [WIDTH-1:0]     data_out;
  logic                 valid_out;
  logic [CW-1:0]        chan_out;

  modport master (
    output data_in, valid_in, out_ready,
    input  pop_out, data_out, valid_out, chan_out
  );

  modport slave (
    input  data_in, valid_in, out_ready,
    output pop_out, data_out, valid_out, chan_out
  );
endinterface

// File: rtl/mux_rr_nx1.sv
// N-to-1 round-robin lane multiplexer with registered output, backpressure and
// per-channel pop strobes; fixed time-slot or work-conserving arbitration.
module mux_rr_nx1 #(
  parameter int WIDTH     = 8,
  parameter int NCH       = 4,
  parameter int SKIP_IDLE = 0
) (
  input  logic            clk,
  input  logic            reset,
  mux_rr_nx1_if.slave     bus
);
  localparam int CW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]    ptr_r;
  logic [CW-1:0]    sel_s;
  logic [CW-1:0]    next_ptr_s;
  logic [CW:0]      idx_s;
  logic             sel_valid_s;
  logic             adv_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [NCH-1:0]   pop_s;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic [CW-1:0]    chan_r;

  // Explicit wrap at NCH-1 so non-power-of-2 channel counts never reach NCH.
  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == CW'(NCH - 1)) begin
      r = '0;
    end else begin
      r = v + CW'(1);
    end
    return r;
  endfunction

  // Pick the granted channel from the pointer and valid lanes.
  always_comb begin
    adv_s = bus.out_ready & reset;
    sel_s = ptr_r;
    idx_s = '0;
    if (SKIP_IDLE != 0) begin
      // Scan backwards so the channel nearest ptr wins by being written last.
      for (int k = NCH - 1; k >= 0; k--) begin
        idx_s = {1'b0, ptr_r} + (CW+1)'(k);
        if (idx_s >= (CW+1)'(NCH)) begin
          idx_s = idx_s - (CW+1)'(NCH);
        end else begin
          idx_s = idx_s;
        end
        if (bus.valid_in[idx_s[CW-1:0]]) begin
          sel_s = idx_s[CW-1:0];
        end else begin
          sel_s = sel_s;
        end
      end
    end else begin
      sel_s = ptr_r;
    end
  end

  // Route the selected lane and build the one-hot pop strobe.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    pop_s       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_s == CW'(i)) begin
        sel_valid_s = bus.valid_in[i];
        sel_data_s  = bus.data_in[i*WIDTH +: WIDTH];
        pop_s[i]    = adv_s & bus.valid_in[i];
      end else begin
        pop_s[i]    = 1'b0;
      end
    end
  end

  // Time-slot mode always steps; work-conserving mode moves past the winner only.
  always_comb begin
    next_ptr_s = ptr_r;
    if (SKIP_IDLE != 0) begin
      if (sel_valid_s) begin
        next_ptr_s = wrap_inc(sel_s);
      end else begin
        next_ptr_s = ptr_r;
      end
    end else begin
      next_ptr_s = wrap_inc(ptr_r);
    end
  end

  // Output register and pointer; idle slots emit zero data, never stale words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      chan_r  <= '0;
      ptr_r   <= '0;
    end else if (adv_s) begin
      data_r  <= sel_valid_s ? sel_data_s : '0;
      valid_r <= sel_valid_s;
      chan_r  <= sel_s;
      ptr_r   <= next_ptr_s;
    end
  end

  assign bus.pop_out   = pop_s;
  assign bus.data_out  = data_r;
  assign bus.valid_out = valid_r;
  assign bus.chan_out  = chan_r;
endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed bench for mux_rr_nx1: three instances (4-ch time-slot, 4-ch
// work-conserving, 3-ch time-slot) driven side by side against hand tables.
module tb_mux_rr_nx1;
  logic clk = 1'b0;
  logic reset;
  int   total_checks = 0;
  int   pass_checks  = 0;

  always #5 clk = ~clk;

  mux_rr_nx1_if #(.WIDTH(8), .NCH(4)) if_ts4 ();
  mux_rr_nx1_if #(.WIDTH(8), .NCH(4)) if_sk4 ();
  mux_rr_nx1_if #(.WIDTH(8), .NCH(3)) if_ts3 ();

  mux_rr_nx1 #(.WIDTH(8), .NCH(4), .SKIP_IDLE(0)) u_ts4 (.clk(clk), .reset(reset), .bus(if_ts4));
  mux_rr_nx1 #(.WIDTH(8), .NCH(4), .SKIP_IDLE(1)) u_sk4 (.clk(clk), .reset(reset), .bus(if_sk4));
  mux_rr_nx1 #(.WIDTH(8), .NCH(3), .SKIP_IDLE(0)) u_ts3 (.clk(clk), .reset(reset), .bus(if_ts3));

  // Expected time-slot pattern for valid_in = 4'b1011.
  logic [7:0] ts_data [4] = '{8'h11, 8'h22, 8'h00, 8'h44};
  logic       ts_vld  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] ts_pop  [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b1000};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs === exp) begin
      pass_checks++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_sk4(input string tag, input logic [7:0] d, input logic v, input logic [1:0] c);
    check_val({tag, " data"}, 32'(if_sk4.data_out), 32'(d));
    check_val({tag, " valid"}, 32'(if_sk4.valid_out), 32'(v));
    check_val({tag, " chan"}, 32'(if_sk4.chan_out), 32'(c));
  endtask

  initial begin
    reset = 1'b0;
    if_ts4.data_in = 32'h44332211; if_ts4.valid_in = 4'b1111; if_ts4.out_ready = 1'b1;
    if_sk4.data_in = 32'h44332211; if_sk4.valid_in = 4'b1111; if_sk4.out_ready = 1'b1;
    if_ts3.data_in = 24'h332211;   if_ts3.valid_in = 3'b111;  if_ts3.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst ts4 data", 32'(if_ts4.data_out), 32'h0);
    check_val("rst ts4 valid", 32'(if_ts4.valid_out), 32'h0);
    check_val("rst ts4 chan", 32'(if_ts4.chan_out), 32'h0);
    check_val("rst ts4 pop", 32'(if_ts4.pop_out), 32'h0);
    check_sk4("rst sk4", 8'h00, 1'b0, 2'd0);
    check_val("rst sk4 pop", 32'(if_sk4.pop_out), 32'h0);
    check_val("rst ts3 pop", 32'(if_ts3.pop_out), 32'h0);
    check_val("rst ts3 valid", 32'(if_ts3.valid_out), 32'h0);

    @(negedge clk);
    if_ts4.valid_in = 4'b1011;
    if_sk4.valid_in = 4'b1010;
    reset = 1'b1;
    #1;
    check_val("ts4 pop first", 32'(if_ts4.pop_out), 32'h1);
    check_val("sk4 pop first", 32'(if_sk4.pop_out), 32'h2);
    check_val("ts3 pop first", 32'(if_ts3.pop_out), 32'h1);

    for (int j = 0; j < 9; j++) begin
      step();
      check_val($sformatf("ts4 data j%0d", j), 32'(if_ts4.data_out), 32'(ts_data[j%4]));
      check_val($sformatf("ts4 valid j%0d", j), 32'(if_ts4.valid_out), 32'(ts_vld[j%4]));
      check_val($sformatf("ts4 chan j%0d", j), 32'(if_ts4.chan_out), 32'(j%4));
      check_sk4($sformatf("sk4 j%0d", j), (j%2 == 0) ? 8'h22 : 8'h44, 1'b1, (j%2 == 0) ? 2'd1 : 2'd3);
      check_val($sformatf("ts3 data j%0d", j), 32'(if_ts3.data_out), 32'(8'h11 * ((j%3) + 1)));
      check_val($sformatf("ts3 chan j%0d", j), 32'(if_ts3.chan_out), 32'(j%3));
      #1;
      check_val($sformatf("ts4 pop j%0d", j), 32'(if_ts4.pop_out), 32'(ts_pop[(j+1)%4]));
      check_val($sformatf("sk4 pop j%0d", j), 32'(if_sk4.pop_out), ((j+1)%2 == 0) ? 32'h2 : 32'h8);
      check_val($sformatf("ts3 pop j%0d", j), 32'(if_ts3.pop_out), 32'(1 << ((j+1)%3)));
    end

    // Work-conserving idle: pointer parked at 2 after the last grant to channel 1.
    if_sk4.valid_in = 4'b0000;
    #1 check_val("sk4 idle pop", 32'(if_sk4.pop_out), 32'h0);
    step();
    check_sk4("sk4 idle0", 8'h00, 1'b0, 2'd2);
    step();
    check_sk4("sk4 idle1", 8'h00, 1'b0, 2'd2);

    if_sk4.valid_in = 4'b1111;
    #1 check_val("sk4 pop c2", 32'(if_sk4.pop_out), 32'h4);
    step();
    check_sk4("sk4 pre-stall", 8'h33, 1'b1, 2'd2);

    if_sk4.out_ready = 1'b0;
    if_sk4.valid_in  = 4'b0101;
    for (int s = 0; s < 3; s++) begin
      #1 check_val($sformatf("sk4 stall pop s%0d", s), 32'(if_sk4.pop_out), 32'h0);
      step();
      check_sk4($sformatf("sk4 stall s%0d", s), 8'h33, 1'b1, 2'd2);
    end

    if_sk4.out_ready = 1'b1;
    if_sk4.valid_in  = 4'b1111;
    #1 check_val("sk4 resume pop", 32'(if_sk4.pop_out), 32'h8);
    step();
    check_sk4("sk4 resume c3", 8'h44, 1'b1, 2'd3);
    #1 check_val("sk4 wrap pop", 32'(if_sk4.pop_out), 32'h1);
    step();
    check_sk4("sk4 resume c0", 8'h11, 1'b1, 2'd0);
    step();
    check_sk4("sk4 resume c1", 8'h22, 1'b1, 2'd1);

    // Asynchronous reset between edges must clear outputs at once.
    #2 reset = 1'b0;
    #1;
    check_sk4("sk4 async rst", 8'h00, 1'b0, 2'd0);
    check_val("sk4 async rst pop", 32'(if_sk4.pop_out), 32'h0);
    check_val("ts3 async rst valid", 32'(if_ts3.valid_out), 32'h0);
    check_val("ts4 async rst pop", 32'(if_ts4.pop_out), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("sk4 post-rst pop", 32'(if_sk4.pop_out), 32'h1);
    check_val("ts4 post-rst pop", 32'(if_ts4.pop_out), 32'h1);
    step();
    check_sk4("sk4 post-rst", 8'h11, 1'b1, 2'd0);
    check_val("ts4 post-rst chan", 32'(if_ts4.chan_out), 32'h0);
    check_val("ts4 post-rst data", 32'(if_ts4.data_out), 32'h11);
    check_val("ts3 post-rst chan", 32'(if_ts3.chan_out), 32'h0);
    check_val("ts3 post-rst data", 32'(if_ts3.data_out), 32'h11);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end
endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
- Parametrised N-to-1 round-robin multiplexer with a registered output.
- Merges NCH valid-qualified byte/word lanes onto one output lane. Each output word carries the index of the channel it came from.
- Two modes: fixed time-slot (strict alternation, idle slots output zero) or work-conserving (skips idle channels).
- Adds output backpressure and per-channel pop strobes, so upstream FIFOs can be drained directly. Sits between the per-lane FIFOs and the serialiser/demux stage.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- NCH, 4, number of input channels (>=2; need not be a power of 2).
- SKIP_IDLE, 0, 0 = fixed time-slot mode; 1 = work-conserving round-robin.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- data_in  input  NCH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- valid_in  input  NCH  per-channel valid; bit i qualifies channel i.
- out_ready  input  1  downstream accept; 0 stalls the block.
- pop_out  output  NCH  combinational, one-hot or zero; bit i = channel i's word is captured at this edge.
- data_out  output  WIDTH  registered output data.
- valid_out  output  1  registered output valid.
- chan_out  output  CW  registered source channel index, where CW = max(1, $clog2(NCH)).

Behaviour:
- Reset:
  - Asynchronous, while reset=0: data_out=0, valid_out=0, chan_out=0, internal pointer ptr=0.
  - pop_out is forced to 0 combinationally while reset=0.
  - Takes effect immediately mid-operation; any word in flight is discarded.
  - First capture after release considers channel 0 first.
- Advance: adv = out_ready & reset.
  - adv=0: data_out, valid_out, chan_out and ptr hold; pop_out=0.
- Latency: a word sampled at edge k appears on data_out/valid_out/chan_out after edge k, i.e. 1 cycle. Throughput is 1 word/cycle while out_ready=1.
- ptr is CW bits and ranges 0..NCH-1. Increment wraps NCH-1 -> 0 explicitly; no power-of-2 wrap.
- SKIP_IDLE=0 (time-slot), on each adv edge with sel=ptr:
  - If valid_in[sel]=1: data_out<=data_in[sel], valid_out<=1, pop_out[sel]=1 during that cycle.
  - Else: data_out<=0, valid_out<=0, no pop.
  - In both cases chan_out<=sel and ptr<=ptr+1 (wrapping). Every channel therefore owns every NCH-th slot regardless of activity.
- SKIP_IDLE=1 (work-conserving), on each adv edge:
  - sel = first i in the order ptr, ptr+1, …, ptr+NCH-1 (mod NCH) with valid_in[i]=1.
  - If found: data_out<=data_in[sel], valid_out<=1, chan_out<=sel, pop_out[sel]=1, ptr<=sel+1 (wrapping).
  - If none: data_out<=0, valid_out<=0, chan_out<=ptr, ptr unchanged.
  - Fairness: a continuously valid channel waits at most NCH-1 grants.
- Valid/data rules:
  - data_out is 0 whenever valid_out=0; it never holds stale data.
  - pop_out depends only on the current ptr, valid_in, out_ready and reset; no path from data_in.
  - At most one pop_out bit is set per cycle.
- Simultaneous events:
  - valid_in toggling in the same cycle as out_ready=0 has no effect; nothing is captured.
  - Reset low on an edge overrides adv.

Test Plan:
- Reset: hold reset=0 with all valid_in=1 and out_ready=1 → data_out=0, valid_out=0, chan_out=0, pop_out=0. After release, first output is chan 0.
- Time-slot mode: NCH=4, SKIP_IDLE=0, data_in lanes = 0x11/0x22/0x33/0x44, valid_in=4'b1011, out_ready=1.
  - Outputs repeat (0x11,v1,c0), (0x22,v1,c1), (0x00,v0,c2), (0x44,v1,c3).
  - pop_out cycles 0001, 0010, 0000, 1000.
- Work-conserving mode: SKIP_IDLE=1, same data, valid_in=4'b1010.
  - Outputs alternate (0x22,c1), (0x44,c3) with valid_out=1 every cycle.
  - With valid_in=0 → valid_out=0, data_out=0, ptr frozen.
- Backpressure: SKIP_IDLE=1, all valid, out_ready low for 3 cycles mid-stream.
  - Output holds its last word and chan; pop_out=0.
  - Sequence resumes at the next channel with no skip and no duplicate.
- Non-power-of-2 wrap: NCH=3, SKIP_IDLE=0, all valid → chan_out sequence 0,1,2,0,1,2; never 3.
- Async reset mid-stream: assert reset=0 between clock edges while valid_out=1 → outputs clear immediately, without waiting for an edge. After release, output restarts at channel 0.
